// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold/load/clear/set, single-step shift/rotate,
// and multi-cycle shift/rotate by a programmable count with busy/done handshake.
module univ_shift_reg #(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      CNT_W   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        M_HOLD = 3'd0,
        M_LOAD = 3'd1,
        M_SHL  = 3'd2,
        M_SHR  = 3'd3,
        M_ROTL = 3'd4,
        M_ROTR = 3'd5,
        M_CLR  = 3'd6,
        M_SET  = 3'd7
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nx;
    mode_t              r_op, w_op_nx;
    logic [WIDTH-1:0]   r_q, w_q_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic               r_busy, w_busy_nx;
    logic               r_done, w_done_nx;

    mode_t              w_mode;
    logic               w_multi;

    assign w_mode  = mode_t'(mode);
    assign w_multi = (w_mode == M_SHL) || (w_mode == M_SHR) ||
                     (w_mode == M_ROTL) || (w_mode == M_ROTR);

    function automatic logic [WIDTH-1:0] f_apply(
        input mode_t            op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sl,
        input logic             sr
    );
        case (op)
            M_LOAD:  f_apply = din;
            M_SHL:   f_apply = {cur[WIDTH-2:0], sl};
            M_SHR:   f_apply = {sr, cur[WIDTH-1:1]};
            M_ROTL:  f_apply = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROTR:  f_apply = {cur[0], cur[WIDTH-1:1]};
            M_CLR:   f_apply = '0;
            M_SET:   f_apply = '1;
            default: f_apply = cur;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= M_HOLD;
            r_q     <= RST_VAL;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_op    <= w_op_nx;
            r_q     <= w_q_nx;
            r_cnt   <= w_cnt_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

    // busy mirrors the next state so it is high exactly while RUN is occupied
    always_comb begin
        w_state_nx = r_state;
        w_op_nx    = r_op;
        w_q_nx     = r_q;
        w_cnt_nx   = r_cnt;
        w_busy_nx  = 1'b0;
        w_done_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && w_multi) begin
                    if (shamt != '0) begin
                        w_op_nx    = w_mode;
                        w_cnt_nx   = shamt;
                        w_state_nx = S_RUN;
                        w_busy_nx  = 1'b1;
                    end else begin
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_q_nx = f_apply(w_mode, r_q, d, sin_l, sin_r);
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_q_nx   = f_apply(r_op, r_q, d, sin_l, sin_r);
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_busy_nx  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign q      = r_q;
    assign qbar   = ~r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against an arithmetic model.
module tb_univ_shift_reg;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROTL = 3'd4, ROTR = 3'd5, CLR = 3'd6, SET = 3'd7;
    localparam int unsigned RSTV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst, start, abort, sin_l, sin_r;
    logic [2:0] mode;
    logic [3:0] shamt;
    logic [7:0] d, q, qbar;
    logic       sout_l, sout_r, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned m_q, m_op;
    int          m_rem;
    bit          m_busy, m_done;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4), .RST_VAL(8'h3C)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .abort(abort),
        .shamt(shamt), .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q), .qbar(qbar),
        .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic       start, abort;
        logic [3:0] shamt;
        logic [7:0] d;
        logic       sl, sr;
        logic [7:0] eq;
        logic       eb, ed;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic [2:0] m, input logic s, input logic a,
                                input logic [3:0] sh, input logic [7:0] dd,
                                input logic sl, input logic sr,
                                input logic [7:0] eq, input logic eb, input logic ed);
        vec_t v;
        v.mode = m; v.start = s; v.abort = a; v.shamt = sh; v.d = dd;
        v.sl = sl; v.sr = sr; v.eq = eq; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register update rules expressed as plain arithmetic on an 8-bit value
    function automatic int unsigned ref_step(input int unsigned op, input int unsigned cur,
                                             input int unsigned dd, input bit sl, input bit sr);
        case (op)
            1:       return dd;
            2:       return (cur * 2 + sl) % 256;
            3:       return cur / 2 + sr * 128;
            4:       return (cur * 2) % 256 + cur / 128;
            5:       return cur / 2 + (cur % 2) * 128;
            6:       return 0;
            7:       return 255;
            default: return cur;
        endcase
    endfunction

    task automatic model_reset();
        m_q = RSTV; m_op = 0; m_rem = 0; m_busy = 0; m_done = 0;
    endtask

    task automatic model_edge();
        bit nd = 0;
        if (!m_busy) begin
            if (start && mode >= 2 && mode <= 5) begin
                if (shamt == 0) nd = 1;
                else begin
                    m_busy = 1; m_rem = int'(shamt); m_op = mode;
                end
            end else begin
                m_q = ref_step(mode, m_q, d, sin_l, sin_r);
            end
        end else if (abort) begin
            m_busy = 0;
        end else begin
            m_q = ref_step(m_op, m_q, d, sin_l, sin_r);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 0; nd = 1;
            end
        end
        m_done = nd;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_q"},      q,      m_q);
        chk({tag, "_qbar"},   qbar,   255 - m_q);
        chk({tag, "_sout_l"}, sout_l, m_q / 128);
        chk({tag, "_sout_r"}, sout_r, m_q % 2);
        chk({tag, "_busy"},   busy,   m_busy);
        chk({tag, "_done"},   done,   m_done);
    endtask

    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_q"},    q,    RSTV);
        chk({tag, "_qbar"}, qbar, ~RSTV & 8'hFF);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        rst = 1'b0;
        #1;
    endtask

    task automatic set_in(input logic [2:0] m, input logic s, input logic [3:0] sh);
        mode = m; start = s; shamt = sh; abort = 1'b0;
    endtask

    initial begin
        logic [7:0] nq;
        int         dcnt;

        vt[0]  = mk(LOAD, 0, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
        vt[1]  = mk(SHL,  0, 0, 0, 8'h00, 1, 0, 8'h4B, 0, 0);
        vt[2]  = mk(SHR,  0, 0, 0, 8'h00, 0, 1, 8'hA5, 0, 0);
        vt[3]  = mk(ROTL, 1, 0, 3, 8'h00, 0, 0, 8'hA5, 1, 0);
        vt[4]  = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h4B, 1, 0);
        vt[5]  = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h96, 1, 0);
        vt[6]  = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h2D, 0, 1);
        vt[7]  = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h2D, 0, 0);
        vt[8]  = mk(CLR,  0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        vt[9]  = mk(SET,  0, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        vt[10] = mk(ROTR, 0, 0, 0, 8'h00, 0, 0, 8'hFF, 0, 0);
        vt[11] = mk(LOAD, 0, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
        vt[12] = mk(ROTR, 1, 0, 5, 8'h00, 0, 0, 8'h81, 1, 0);
        vt[13] = mk(LOAD, 1, 0, 9, 8'h00, 0, 0, 8'hC0, 1, 0);
        vt[14] = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h60, 1, 0);
        vt[15] = mk(HOLD, 0, 1, 0, 8'h00, 0, 0, 8'h60, 0, 0);
        vt[16] = mk(HOLD, 0, 1, 0, 8'h00, 0, 0, 8'h60, 0, 0);
        vt[17] = mk(SHL,  1, 0, 0, 8'h00, 1, 1, 8'h60, 0, 1);
        vt[18] = mk(HOLD, 0, 0, 0, 8'h00, 0, 0, 8'h60, 0, 0);

        rst = 1'b1; mode = HOLD; start = 0; abort = 0; shamt = 0; d = 0;
        sin_l = 0; sin_r = 0;
        #1;
        model_reset();
        chk("rst_q", q, RSTV);
        chk("rst_qbar", qbar, 8'hC3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;

        for (int i = 0; i < 19; i++) begin
            mode = vt[i].mode; start = vt[i].start; abort = vt[i].abort;
            shamt = vt[i].shamt; d = vt[i].d; sin_l = vt[i].sl; sin_r = vt[i].sr;
            cycle("tbl_model");
            nq = ~vt[i].eq;
            chk($sformatf("tbl%0d_q", i), q, vt[i].eq);
            chk($sformatf("tbl%0d_qbar", i), qbar, nq);
            chk($sformatf("tbl%0d_busy", i), busy, vt[i].eb);
            chk($sformatf("tbl%0d_done", i), done, vt[i].ed);
        end

        // Asynchronous reset in the middle of a multi-cycle rotate
        d = 8'h5A; set_in(LOAD, 0, 0); cycle("mid_load");
        set_in(ROTL, 1, 8); cycle("mid_acc");
        set_in(HOLD, 0, 0); cycle("mid_s1"); cycle("mid_s2");
        chk("mid_busy_before", busy, 1);
        do_reset("mid_rst");
        set_in(HOLD, 0, 0); cycle("mid_hold");
        chk("mid_hold_q", q, 8'h3C);
        chk("mid_hold_busy", busy, 0);

        // Shift count beyond width flushes to the serial input; then back-to-back start
        d = 8'hFF; set_in(LOAD, 0, 0); cycle("fl_load");
        sin_r = 0; set_in(SHR, 1, 10); cycle("fl_acc");
        set_in(LOAD, 0, 0); d = 8'hAA;
        dcnt = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle("fl_step");
            chk($sformatf("fl_busy%0d", i), busy, (i < 10) ? 1 : 0);
            if (done) dcnt++;
        end
        chk("fl_q", q, 8'h00);
        chk("fl_done_cnt", dcnt, 1);
        set_in(ROTL, 1, 2); cycle("b2b_acc");
        chk("b2b_busy", busy, 1);
        set_in(HOLD, 0, 0); cycle("b2b_s1"); cycle("b2b_s2");
        chk("b2b_done", done, 1);
        cycle("b2b_idle");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            mode  = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 15) == 0);
            shamt = 4'($urandom_range(0, 15));
            d     = 8'($urandom);
            sin_l = 1'($urandom);
            sin_r = 1'($urandom);
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
